// File: rtl/stream_gather_unit.sv
// Pull-side D2Q9 gather: reads the nine upstream post-collision distributions of one node
// and presents them as a packed 9-lane vector with an in-grid lane mask.
module stream_gather_unit #(
  parameter int GRID_X        = 16,
  parameter int GRID_Y        = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int ADDRESS_WIDTH = $clog2(9*GRID_X*GRID_Y)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(GRID_X)-1:0] req_x,
  input  logic [$clog2(GRID_Y)-1:0] req_y,
  output logic                      mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [9*DATA_WIDTH-1:0]   out_f,
  output logic [8:0]                out_mask
);

  localparam int XW = $clog2(GRID_X);
  localparam int YW = $clog2(GRID_Y);
  localparam int SW = ((XW > YW) ? XW : YW) + 2;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic signed [SW-1:0] GX_S = SW'(GRID_X);
  localparam logic signed [SW-1:0] GY_S = SW'(GRID_Y);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t                         state_q, state_d;
  logic [XW-1:0]                  x_q, x_d;
  logic [YW-1:0]                  y_q, y_d;
  logic                           oob_q, oob_d;
  logic [3:0]                     q_q, q_d;
  logic [LW-1:0]                  drain_q, drain_d;
  logic [8:0]                     mask_q, mask_d;
  logic [9*DATA_WIDTH-1:0]        f_q, f_d;
  logic [RD_LATENCY-1:0]          pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0][3:0]     pipe_lane_q, pipe_lane_d;

  logic signed [SW-1:0]           xs, ys;
  logic                           lane_ok;
  logic                           issue_en;
  logic [ADDRESS_WIDTH-1:0]       addr;

  function automatic logic signed [SW-1:0] vel_x(input logic [3:0] q);
    case (q)
      4'd1, 4'd5, 4'd8: vel_x = SW'(1);
      4'd3, 4'd6, 4'd7: vel_x = '1;
      default:          vel_x = '0;
    endcase
  endfunction

  function automatic logic signed [SW-1:0] vel_y(input logic [3:0] q);
    case (q)
      4'd2, 4'd5, 4'd6: vel_y = SW'(1);
      4'd4, 4'd7, 4'd8: vel_y = '1;
      default:          vel_y = '0;
    endcase
  endfunction

  // Source node = destination minus velocity; the sign bit flags a left/bottom overrun.
  always_comb begin
    xs       = signed'(SW'(x_q)) - vel_x(q_q);
    ys       = signed'(SW'(y_q)) - vel_y(q_q);
    lane_ok  = !oob_q && !xs[SW-1] && (xs < GX_S) && !ys[SW-1] && (ys < GY_S);
    issue_en = (state_q == ISSUE) && lane_ok;
    addr     = ADDRESS_WIDTH'(q_q) * ADDRESS_WIDTH'(GRID_X * GRID_Y)
             + ADDRESS_WIDTH'(unsigned'(ys)) * ADDRESS_WIDTH'(GRID_X)
             + ADDRESS_WIDTH'(unsigned'(xs));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    oob_d   = oob_q;
    q_d     = q_q;
    drain_d = drain_q;
    mask_d  = mask_q;
    f_d     = f_q;

    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_lane_d[i] = pipe_lane_q[i-1];
    end
    pipe_v_d[0]    = issue_en;
    pipe_lane_d[0] = q_q;

    if (pipe_v_q[RD_LATENCY-1])
      f_d[pipe_lane_q[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          oob_d   = (32'(req_x) >= 32'(GRID_X)) || (32'(req_y) >= 32'(GRID_Y));
          q_d     = '0;
          f_d     = '0;
          mask_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mask_d[q_q] = lane_ok;
        if (q_q == 4'd8) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          q_d = q_q + 4'd1;
        end
      end
      DRAIN: begin
        // The last read lands in the final drain cycle and is captured on its closing edge.
        if (drain_q == LW'(RD_LATENCY - 1)) state_d = HOLD;
        else                                drain_d = drain_q + LW'(1);
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      oob_q       <= 1'b0;
      q_q         <= '0;
      drain_q     <= '0;
      mask_q      <= '0;
      f_q         <= '0;
      pipe_v_q    <= '0;
      pipe_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      oob_q       <= oob_d;
      q_q         <= q_d;
      drain_q     <= drain_d;
      mask_q      <= mask_d;
      f_q         <= f_d;
      pipe_v_q    <= pipe_v_d;
      pipe_lane_q <= pipe_lane_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign out_f       = f_q;
  assign out_mask    = mask_q;
  assign mem_rd_en   = issue_en;
  assign mem_rd_addr = issue_en ? addr : '0;

endmodule
